// File: rtl/counter_pkg.sv
// Shared encodings for the counter family (event/timebase, timer and PWM blocks).
// Function-free so any block can import it without dragging in logic.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage : counter_pkg

// File: rtl/mod_updown_counter_step_calc.sv
// Combinational next-value calculator for a 0..limit counter stepping by s.
// Works at SIZE+1 bits so limit = 2^SIZE-1 wraps without losing the carry.
module mod_step_calc
  import counter_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] count,
  input  logic [SIZE:0]   s,
  input  logic [SIZE-1:0] limit,
  input  logic            up_down,
  input  logic            mode,
  output logic [SIZE-1:0] next,
  output logic            cross_up,
  output logic            cross_down
);

  logic [SIZE:0] c_x;
  logic [SIZE:0] lim_x;
  logic [SIZE:0] span_x;
  logic [SIZE:0] sum_x;

  always_comb begin
    c_x        = {1'b0, count};
    lim_x      = {1'b0, limit};
    span_x     = lim_x + {{SIZE{1'b0}}, 1'b1};
    sum_x      = c_x + s;
    next       = count;
    cross_up   = 1'b0;
    cross_down = 1'b0;

    if (up_down == DIR_UP) begin
      if (sum_x > lim_x) begin
        cross_up = 1'b1;
        next     = (mode == MODE_SAT) ? limit : SIZE'(sum_x - span_x);
      end else begin
        next = SIZE'(sum_x);
      end
    end else begin
      if (s > c_x) begin
        cross_down = 1'b1;
        // c + (limit+1) - s stays below 2^(SIZE+1), so no wrap in the intermediate
        next       = (mode == MODE_SAT) ? '0 : SIZE'(c_x + span_x - s);
      end else begin
        next = SIZE'(c_x - s);
      end
    end
  end

endmodule : mod_step_calc

// File: rtl/mod_updown_counter.sv
// General-purpose up/down counter: runtime modulus and step, wrap/saturate,
// synchronous load, registered terminal-count pulse and sticky ovf/unf flags.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              up_down,
  input  logic              mode,
  input  logic [STEP_W-1:0] step,
  input  logic [SIZE-1:0]   limit,
  input  logic              load_en,
  input  logic [SIZE-1:0]   load,
  input  logic              clear_flags,
  output logic [SIZE-1:0]   count,
  output logic              tc,
  output logic              ovf,
  output logic              unf
);

  localparam int EW = (STEP_W > SIZE + 1) ? STEP_W : SIZE + 1;

  logic [SIZE-1:0] count_q, count_d;
  logic            tc_q, tc_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [EW-1:0]   step_x;
  logic [EW-1:0]   span_x;
  logic [SIZE:0]   s_eff;
  logic [SIZE-1:0] calc_next;
  logic            calc_cross_up;
  logic            calc_cross_down;

  // Effective step never exceeds one full lap of the modulus.
  always_comb begin
    step_x = EW'(step);
    span_x = EW'(limit) + EW'(1);
    s_eff  = (step_x < span_x) ? (SIZE + 1)'(step_x) : (SIZE + 1)'(span_x);
  end

  mod_step_calc #(
    .SIZE (SIZE)
  ) u_step_calc (
    .count      (count_q),
    .s          (s_eff),
    .limit      (limit),
    .up_down    (up_down),
    .mode       (mode),
    .next       (calc_next),
    .cross_up   (calc_cross_up),
    .cross_down (calc_cross_down)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~clear_flags;
    unf_d   = unf_q & ~clear_flags;

    if (load_en) begin
      count_d = (load > limit) ? limit : load;
    end else if (count_q > limit) begin
      count_d = limit;
    end else if (enable && (step != '0)) begin
      count_d = calc_next;
      tc_d    = calc_cross_up | calc_cross_down;
      // A same-edge crossing overrides clear_flags.
      if (calc_cross_up)   ovf_d = 1'b1;
      if (calc_cross_down) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter (SIZE=8, STEP_W=4).
`timescale 1ns/1ps
module tb_mod_updown_counter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       mode;
  logic [3:0] step;
  logic [7:0] limit;
  logic       load_en;
  logic [7:0] load;
  logic       clear_flags;
  logic [7:0] count;
  logic       tc;
  logic       ovf;
  logic       unf;

  int unsigned n_pass;
  int unsigned n_total;

  mod_updown_counter #(
    .SIZE   (8),
    .STEP_W (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .up_down     (up_down),
    .mode        (mode),
    .step        (step),
    .limit       (limit),
    .load_en     (load_en),
    .load        (load),
    .clear_flags (clear_flags),
    .count       (count),
    .tc          (tc),
    .ovf         (ovf),
    .unf         (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; up_down = 1'b1; mode = 1'b0; step = '0;
    limit = 8'd255; load_en = 1'b0; load = '0; clear_flags = 1'b0;
    tick(); tick();
    n_total++;
    if ({count, tc, ovf, unf} !== 11'd0)
      $display("FAIL reset_state: count=%0d tc=%b ovf=%b unf=%b, required all 0", count, tc, ovf, unf);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_wrap_up();
    logic [7:0] exp_cnt [5];
    logic       exp_tc  [5];
    exp_cnt = '{8'd3, 8'd6, 8'd9, 8'd2, 8'd5};
    exp_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    limit = 8'd9; mode = 1'b0; up_down = 1'b1; step = 4'd3;
    load_en = 1'b1; load = 8'd0; enable = 1'b0;
    tick();
    load_en = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (count !== exp_cnt[i] || tc !== exp_tc[i])
        $display("FAIL wrap_up_edge%0d: count=%0d tc=%b, required count=%0d tc=%b",
                 i + 1, count, tc, exp_cnt[i], exp_tc[i]);
      else n_pass++;
    end
    enable = 1'b0;
    n_total++;
    if (ovf !== 1'b1 || unf !== 1'b0)
      $display("FAIL wrap_up_flags: ovf=%b unf=%b, required ovf=1 unf=0", ovf, unf);
    else n_pass++;
  endtask

  task automatic test_sat_down();
    logic [7:0] exp_cnt [3];
    logic       exp_tc  [3];
    exp_cnt = '{8'd1, 8'd0, 8'd0};
    exp_tc  = '{1'b0, 1'b1, 1'b1};
    limit = 8'd200; mode = 1'b1; load_en = 1'b1; load = 8'd4; enable = 1'b0;
    tick();
    load_en = 1'b0; step = 4'd3; up_down = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (count !== exp_cnt[i] || tc !== exp_tc[i])
        $display("FAIL sat_down_edge%0d: count=%0d tc=%b, required count=%0d tc=%b",
                 i + 1, count, tc, exp_cnt[i], exp_tc[i]);
      else n_pass++;
    end
    enable = 1'b0;
    n_total++;
    if (unf !== 1'b1)
      $display("FAIL sat_down_unf: unf=%b, required 1", unf);
    else n_pass++;
  endtask

  task automatic test_load_priority();
    mode = 1'b0; up_down = 1'b1; step = 4'd3;
    limit = 8'd100; load = 8'd250; load_en = 1'b1; enable = 1'b1;
    tick();
    n_total++;
    if (count !== 8'd100 || tc !== 1'b0)
      $display("FAIL load_clamp: count=%0d tc=%b, required count=100 tc=0", count, tc);
    else n_pass++;
    load_en = 1'b0; enable = 1'b0; limit = 8'd50;
    tick();
    n_total++;
    if (count !== 8'd50 || tc !== 1'b0)
      $display("FAIL limit_lowered: count=%0d tc=%b, required count=50 tc=0", count, tc);
    else n_pass++;
  endtask

  task automatic test_boundary();
    limit = 8'd255; mode = 1'b0; load_en = 1'b1; load = 8'd254; enable = 1'b0;
    tick();
    load_en = 1'b0; step = 4'd2; up_down = 1'b1; enable = 1'b1;
    tick();
    n_total++;
    if (count !== 8'd0 || tc !== 1'b1)
      $display("FAIL full_wrap: count=%0d tc=%b, required count=0 tc=1", count, tc);
    else n_pass++;
    step = 4'd0;
    tick();
    n_total++;
    if (count !== 8'd0 || tc !== 1'b0)
      $display("FAIL step_zero_hold: count=%0d tc=%b, required count=0 tc=0", count, tc);
    else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_flags();
    enable = 1'b0; clear_flags = 1'b1;
    tick();
    n_total++;
    if (ovf !== 1'b0 || unf !== 1'b0)
      $display("FAIL clear_no_cross: ovf=%b unf=%b, required 0 0", ovf, unf);
    else n_pass++;
    clear_flags = 1'b0; limit = 8'd9; mode = 1'b0; load_en = 1'b1; load = 8'd9;
    tick();
    load_en = 1'b0; step = 4'd1; up_down = 1'b1; enable = 1'b1; clear_flags = 1'b1;
    tick();
    n_total++;
    if (count !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1)
      $display("FAIL clear_vs_set: count=%0d tc=%b ovf=%b, required count=0 tc=1 ovf=1", count, tc, ovf);
    else n_pass++;
    enable = 1'b0;
    tick();
    n_total++;
    if (ovf !== 1'b0 || tc !== 1'b0)
      $display("FAIL clear_after_set: ovf=%b tc=%b, required 0 0", ovf, tc);
    else n_pass++;
    clear_flags = 1'b0;
  endtask

  task automatic test_limit_zero();
    limit = 8'd0; mode = 1'b0; load_en = 1'b1; load = 8'd5; enable = 1'b0;
    tick();
    n_total++;
    if (count !== 8'd0)
      $display("FAIL limit0_load: count=%0d, required 0", count);
    else n_pass++;
    load_en = 1'b0; step = 4'd4; up_down = 1'b1; enable = 1'b1;
    tick();
    n_total++;
    if (count !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1 || unf !== 1'b0)
      $display("FAIL limit0_up: count=%0d tc=%b ovf=%b unf=%b, required 0 1 1 0", count, tc, ovf, unf);
    else n_pass++;
    up_down = 1'b0;
    tick();
    n_total++;
    if (count !== 8'd0 || tc !== 1'b1 || unf !== 1'b1)
      $display("FAIL limit0_down: count=%0d tc=%b unf=%b, required 0 1 1", count, tc, unf);
    else n_pass++;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    limit = 8'd3; mode = 1'b1; load_en = 1'b1; load = 8'd2; enable = 1'b0;
    tick();
    load_en = 1'b0; step = 4'd2; up_down = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (count !== 8'd3 || tc !== 1'b1)
        $display("FAIL back_to_back_edge%0d: count=%0d tc=%b, required count=3 tc=1", i + 1, count, tc);
      else n_pass++;
    end
    enable = 1'b0;
    tick();
    n_total++;
    if (tc !== 1'b0)
      $display("FAIL back_to_back_end: tc=%b, required 0", tc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_count();
    limit = 8'd200; mode = 1'b0; load_en = 1'b1; load = 8'd37; enable = 1'b0;
    tick();
    n_total++;
    if (count !== 8'd37)
      $display("FAIL mid_reset_setup: count=%0d, required 37", count);
    else n_pass++;
    load_en = 1'b1; load = 8'd99; enable = 1'b1; step = 4'd1; up_down = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({count, tc, ovf, unf} !== 11'd0)
      $display("FAIL mid_reset_async: count=%0d tc=%b ovf=%b unf=%b, required all 0", count, tc, ovf, unf);
    else n_pass++;
    tick();
    n_total++;
    if (count !== 8'd0)
      $display("FAIL reset_over_load: count=%0d, required 0", count);
    else n_pass++;
    reset = 1'b0; load_en = 1'b0; enable = 1'b0;
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_priority();
    test_boundary();
    test_flags();
    test_limit_zero();
    test_back_to_back();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mod_updown_counter

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised up/down counter generalising the team's basic SIZE-bit counter: programmable modulus (runtime `limit`), programmable step, wrap or saturate mode, synchronous load, a registered terminal-count pulse and sticky overflow/underflow flags. It is the general-purpose event/timebase counter for the timer and PWM blocks, replacing the fixed-step counter in new designs.

## Interface
- `SIZE`, 8, counter width in bits.
- `STEP_W`, 4, width of the step input.
- `clk`  in  1  rising-edge clock; only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  count-step qualifier.
- `up_down`  in  1  1 = count up, 0 = count down.
- `mode`  in  1  0 = wrap (modulo limit+1), 1 = saturate.
- `step`  in  STEP_W  increment/decrement magnitude; 0 = hold.
- `limit`  in  SIZE  maximum count value; range is 0..limit.
- `load_en`  in  1  synchronous load strobe.
- `load`  in  SIZE  load value.
- `clear_flags`  in  1  clears `ovf`/`unf`.
- `count`  out  SIZE  current count (registered).
- `tc`  out  1  one-cycle terminal-count pulse (registered).
- `ovf`  out  1  sticky: an up step crossed `limit`.
- `unf`  out  1  sticky: a down step crossed 0.

## Operation
- Reset (async assert): `count`=0, `tc`=0, `ovf`=0, `unf`=0. Deassertion takes effect at the next `clk` edge.
- Priority per edge: `load_en` > limit-clamp > `enable` step > hold.
- Load: `count` <= min(`load`, `limit`). No `tc`. Flags unchanged.
- Limit-clamp: if `load_en`=0 and `count` > `limit` (limit lowered at runtime), `count` <= `limit` regardless of `enable`. No `tc`. No flags.
- Step (`enable`=1, `step`≠0). Arithmetic is done at SIZE+1 bits. Effective step s = min(`step`, `limit`+1).
  - Up, `count`+s ≤ `limit`: `count`+s.
  - Up, `count`+s > `limit`: wrap gives `count`+s−(`limit`+1); saturate gives `limit`. Either way `tc`=1 and `ovf` set.
  - Down, s ≤ `count`: `count`−s.
  - Down, s > `count`: wrap gives `count`+(`limit`+1)−s; saturate gives 0. Either way `tc`=1 and `unf` set.
- Saturate mode at the boundary: each further enabled step outward re-pulses `tc` and keeps the flag set. Count stays put.
- `step`=0 with `enable`=1: hold, no `tc`.
- `limit`=0: count is stuck at 0; every enabled nonzero step fires `tc` and sets the corresponding flag.
- `limit`=2^SIZE−1: full natural wrap; the SIZE+1 intermediate prevents carry loss.
- `clear_flags` with a same-edge flag set: set wins, so the flag stays 1.

## Timing
- Single-cycle latency: inputs sampled at edge N; `count`, `tc` and flags are valid after edge N.
- `tc` is high for exactly the cycle after the crossing step. Back-to-back crossings give back-to-back pulses.
- `limit` and `mode` are sampled every edge. A change takes effect on the next step with no pipeline.
- Reset mid-count clears all outputs immediately (async) and overrides a same-cycle `load_en`.

## Structure
- Shared package `counter_pkg`:
  - `MODE_WRAP`=1'b0 and `MODE_SAT`=1'b1 constants.
  - `DIR_UP`=1'b1 and `DIR_DOWN`=1'b0 constants.
  - Function-free so it can be imported by the timer and PWM blocks.
- One combinational sub-module, `mod_step_calc`:
  - Inputs: count, s, limit, up_down, mode.
  - Outputs: next value, cross_up, cross_down.
  - Reusable by the PWM block.
- Top holds the registers, priority mux, and flag logic.

## Test plan
All scenarios use SIZE=8, STEP_W=4.
- Reset → count=0, tc=0, ovf=0, unf=0. Assert reset mid-count at count=37 → all outputs 0 within the same cycle.
- Wrap up, limit=9, step=3, load 0, enable 5 edges → count 3, 6, 9, 2, 5. tc pulses only after the 4th edge; ovf=1.
- Saturate down, limit=200, mode=1, load 4, step=3, down → count 1, then 0, then 0. tc pulses on the 2nd and 3rd edges; unf=1.
- Load priority:
  - load_en=1 with load=250, limit=100, enable=1 → count=100 with no tc.
  - Then lower limit to 50 with enable=0 → count=50 at the next edge.
- Boundary, limit=255, wrap, count=254, step=2, up → count=0 and tc=1. Then step=0 with enable=1 → count holds, no tc.
- Flags:
  - clear_flags with no crossing → ovf=0.
  - clear_flags on the same edge as an overflow crossing → ovf stays 1.
